tail_light_seq: RTL and testbench



---
 rtl/tail_light_seq_if.sv | 25 ++
 rtl/tail_light_seq.sv | 119 +++++++++++
 tb/tb_tail_light_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tail_light_seq_if.sv
// Tail-light sequencer signal bundle.
//   sw_left/sw_right/sw_hazard/sw_brake : raw switch requests (asynchronous to clk)
//   CurrentState[3:0]                   : registered state code to the LED decoder
//   counter[2:0]                        : registered sweep step, 0..5
//   hazard[2:0]                         : registered hazard flash pattern, 000 or 111
// master = switch/stimulus side, slave = sequencer side.
interface tail_light_if;
  logic       sw_left;
  logic       sw_right;
  logic       sw_hazard;
  logic       sw_brake;
  logic [3:0] CurrentState;
  logic [2:0] counter;
  logic [2:0] hazard;

  modport master (
    output sw_left, sw_right, sw_hazard, sw_brake,
    input  CurrentState, counter, hazard
  );

  modport slave (
    input  sw_left, sw_right, sw_hazard, sw_brake,
    output CurrentState, counter, hazard
  );
endinterface

// File: rtl/tail_light_seq.sv
// Tail-light sequencing controller.
// Synchronizes the four switch requests, evaluates the light state machine
// every clock, and produces the animation timebase that advances the turn
// sweep counter and the hazard flash pattern.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   tl_io  : tail_light_if.slave (switch inputs, CurrentState/counter/hazard outputs)
// Parameter:
//   TICK_DIV : clocks per animation step (>= 2)
module tail_light_seq #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  tail_light_if.slave   tl_io
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    HAZARD  = 4'b0001,
    BRAKE   = 4'b0011,
    RIGHT   = 4'b0100,
    LEFT    = 4'b0101,
    B_RIGHT = 4'b0110,
    B_LEFT  = 4'b0111
  } state_t;

  // Synchronizer bit order: {H, B, L, R}
  logic [3:0]    sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    counter_q, counter_d;
  logic [2:0]    hazard_q, hazard_d;
  logic          tick;
  logic          changed;
  logic          h, b, l, r;

  function automatic logic is_left_side(input state_t s);
    return (s == LEFT) || (s == B_LEFT);
  endfunction

  function automatic logic is_right_side(input state_t s);
    return (s == RIGHT) || (s == B_RIGHT);
  endfunction

  assign {h, b, l, r} = sync2_q;
  assign tick         = (presc_q == PRESC_MAX);

  always_comb begin
    state_d = IDLE;
    if (h) begin
      state_d = HAZARD;
    end else if (b) begin
      if (l && !r)      state_d = B_LEFT;
      else if (r && !l) state_d = B_RIGHT;
      else              state_d = BRAKE;
    end else if (l && !r) begin
      state_d = LEFT;
    end else if (r && !l) begin
      state_d = RIGHT;
    end

    // An upset into an unused code returns to Idle before normal evaluation.
    case (state_q)
      IDLE, HAZARD, BRAKE, RIGHT, LEFT, B_RIGHT, B_LEFT: ;
      default: state_d = IDLE;
    endcase
  end

  assign changed = (state_d != state_q);

  always_comb begin
    presc_d   = presc_q + PW'(1);
    counter_d = 3'd0;
    hazard_d  = 3'd0;

    if (changed) begin
      // Any tick in this cycle is dropped; entry values take effect instead.
      presc_d = '0;
      if ((is_left_side(state_q) && is_left_side(state_d)) ||
          (is_right_side(state_q) && is_right_side(state_d)))
        counter_d = counter_q;
    end else begin
      if (tick) presc_d = '0;
      if (is_left_side(state_q) || is_right_side(state_q)) begin
        counter_d = counter_q;
        if (tick) counter_d = (counter_q >= 3'd5) ? 3'd0 : counter_q + 3'd1;
      end
      if (state_q == HAZARD) hazard_d = tick ? ~hazard_q : hazard_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      presc_q   <= '0;
      counter_q <= '0;
      hazard_q  <= '0;
    end else begin
      sync1_q   <= {tl_io.sw_hazard, tl_io.sw_brake, tl_io.sw_left, tl_io.sw_right};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      presc_q   <= presc_d;
      counter_q <= counter_d;
      hazard_q  <= hazard_d;
    end
  end

  assign tl_io.CurrentState = state_q;
  assign tl_io.counter      = counter_q;
  assign tl_io.hazard       = hazard_q;

endmodule

// File: tb/tb_tail_light_seq.sv
module tb_tail_light_seq;

  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  tail_light_if tl();

  tail_light_seq #(.TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tl_io (tl.slave)
  );

  always #5 clk = ~clk;

  // Reference model: switches delayed two clocks, state from the priority
  // rules, steps counted as clocks spent in the current state.
  int         m_state, m_cnt, m_haz, m_age;
  logic [3:0] m_s1, m_s2;

  function automatic int rule(input logic [3:0] hblr);
    logic hh, bb, ll, rr, turn;
    {hh, bb, ll, rr} = hblr;
    turn = ll ^ rr;
    if (hh) return 1;
    if (bb) return turn ? (ll ? 7 : 6) : 3;
    return turn ? (ll ? 5 : 4) : 0;
  endfunction

  function automatic int side(input int s);
    if (s == 5 || s == 7) return 1;
    if (s == 4 || s == 6) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_haz = 0; m_age = 0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_edge();
    int want;
    if (!rst_n) begin
      model_reset();
      return;
    end
    want = rule(m_s2);
    m_s2 = m_s1;
    m_s1 = {tl.sw_hazard, tl.sw_brake, tl.sw_left, tl.sw_right};
    if (want != m_state) begin
      if (!(side(want) != 0 && side(want) == side(m_state))) m_cnt = 0;
      m_haz   = 0;
      m_age   = 0;
      m_state = want;
    end else begin
      m_age++;
      if (m_age == TDIV) begin
        m_age = 0;
        if (side(m_state) != 0) m_cnt = (m_cnt + 1) % 6;
        if (m_state == 1) m_haz = (m_haz != 0) ? 0 : 7;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_sw(input logic lf, input logic rt, input logic hz, input logic bk);
    tl.sw_left = lf; tl.sw_right = rt; tl.sw_hazard = hz; tl.sw_brake = bk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_sw(0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_sw(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({tl.CurrentState, tl.counter, tl.hazard} !== 10'd0) begin
        miscompares++;
        $display("FAIL reset_hold: got %b/%b/%b want 0000/000/000", tl.CurrentState, tl.counter, tl.hazard);
      end
    end
    rst_n = 1'b1;
    step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release_early: state %b want 0000", tl.CurrentState);
    end
    step();
    vectors++;
    if (tl.CurrentState !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_release_hazard: state %b want 0001", tl.CurrentState);
    end
  endtask

  task automatic test_left_sweep();
    do_reset();
    set_sw(1, 0, 0, 0);
    step(); step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0101 || tl.counter !== 3'd0) begin
      miscompares++;
      $display("FAIL left_entry: state %b cnt %0d want 0101 cnt 0", tl.CurrentState, tl.counter);
    end
    for (int k = 1; k < 28; k++) begin
      step();
      vectors++;
      if (tl.counter !== 3'((k / TDIV) % 6)) begin
        miscompares++;
        $display("FAIL left_sweep k=%0d: cnt %0d want %0d", k, tl.counter, (k / TDIV) % 6);
      end
    end
  endtask

  task automatic test_brake_mid_turn();
    int n;
    do_reset();
    set_sw(0, 1, 0, 0);
    n = 0;
    while (tl.counter !== 3'd3 && n < 100) begin step(); n++; end
    vectors++;
    if (tl.counter !== 3'd3 || tl.CurrentState !== 4'b0100) begin
      miscompares++;
      $display("FAIL brake_wait: state %b cnt %0d want 0100 cnt 3", tl.CurrentState, tl.counter);
    end
    tl.sw_brake = 1'b1;
    step(); step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0110 || tl.counter !== 3'd3) begin
      miscompares++;
      $display("FAIL brake_enter: state %b cnt %0d want 0110 cnt 3", tl.CurrentState, tl.counter);
    end
    step(); step(); step();
    vectors++;
    if (tl.counter !== 3'd3) begin
      miscompares++;
      $display("FAIL brake_discard_tick: cnt %0d want 3", tl.counter);
    end
    step();
    vectors++;
    if (tl.counter !== 3'd4) begin
      miscompares++;
      $display("FAIL brake_step: cnt %0d want 4", tl.counter);
    end
    tl.sw_brake = 1'b0;
    step(); step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0100 || tl.counter !== 3'd4) begin
      miscompares++;
      $display("FAIL brake_release: state %b cnt %0d want 0100 cnt 4", tl.CurrentState, tl.counter);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    set_sw(1, 0, 1, 1);
    step(); step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0001 || tl.hazard !== 3'd0 || tl.counter !== 3'd0) begin
      miscompares++;
      $display("FAIL hazard_entry: %b/%b/%b want 0001/000/000", tl.CurrentState, tl.counter, tl.hazard);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++;
      if (tl.hazard !== (((k / TDIV) % 2) != 0 ? 3'b111 : 3'b000) || tl.counter !== 3'd0) begin
        miscompares++;
        $display("FAIL hazard_flash k=%0d: haz %b cnt %0d", k, tl.hazard, tl.counter);
      end
    end
    tl.sw_hazard = 1'b0;
    step(); step();
    vectors++;
    if (tl.CurrentState !== 4'b0001 || tl.hazard !== 3'b111) begin
      miscompares++;
      $display("FAIL hazard_hold: state %b haz %b want 0001/111", tl.CurrentState, tl.hazard);
    end
    step();
    vectors++;
    if (tl.CurrentState !== 4'b0111 || tl.hazard !== 3'b000 || tl.counter !== 3'd0) begin
      miscompares++;
      $display("FAIL hazard_exit: %b/%b/%b want 0111/000/000", tl.CurrentState, tl.counter, tl.hazard);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_sw(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (tl.CurrentState !== 4'b0000) begin
        miscompares++;
        $display("FAIL conflict_idle: state %b want 0000", tl.CurrentState);
      end
    end
    tl.sw_brake = 1'b1;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (tl.CurrentState !== 4'b0011 || tl.counter !== 3'd0) begin
        miscompares++;
        $display("FAIL conflict_brake: state %b cnt %0d want 0011 cnt 0", tl.CurrentState, tl.counter);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_sw(1, 0, 0, 1);
    step(); step(); step();
    for (int i = 0; i < 5 * TDIV; i++) step();
    vectors++;
    if (tl.CurrentState !== 4'b0111 || tl.counter !== 3'd5) begin
      miscompares++;
      $display("FAIL async_setup: state %b cnt %0d want 0111 cnt 5", tl.CurrentState, tl.counter);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({tl.CurrentState, tl.counter, tl.hazard} !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b/%b/%b want 0000/000/000", tl.CurrentState, tl.counter, tl.hazard);
    end
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        step();
        vectors++;
        if (tl.CurrentState !== 4'(m_state) || tl.counter !== 3'(m_cnt) || tl.hazard !== 3'(m_haz)) begin
          miscompares++;
          $display("FAIL random seg=%0d: got %b/%0d/%b want %b/%0d/%b", seg,
                   tl.CurrentState, tl.counter, tl.hazard, 4'(m_state), m_cnt, 3'(m_haz));
        end
      end
    end
  endtask

  initial begin
    set_sw(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_left_sweep();
    test_brake_mid_turn();
    test_hazard();
    test_conflict();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
